// File: rtl/btn_enc_pkg.sv
// Shared types for the push-button encoder: FSM states, code type and the
// priority encoder that maps a debounced pattern to a button index.
package btn_enc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PEND = 2'b01,
      HELD = 2'b10
   } state_e;

   typedef logic [1:0] code_t;

   // Highest pressed button wins.
   function automatic code_t prio_enc(input logic [3:0] pat);
      code_t c;
      c = 2'b00;
      if (pat[3]) begin
         c = 2'b11;
      end else if (pat[2]) begin
         c = 2'b10;
      end else if (pat[1]) begin
         c = 2'b01;
      end else begin
         c = 2'b00;
      end
      return c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a shared-counter debouncer for a button
// vector; the debounced pattern only moves after DEBOUNCE_CYCLES stable samples.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned WIDTH           = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn_i,
   output logic [WIDTH-1:0] db_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] db_q;
   logic [WIDTH-1:0] db_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // Stability counter: sync1 != sync2 means sync2 is about to change, so restart.
   always_comb begin
      db_d  = db_q;
      cnt_d = {CW{1'b0}};
      if (sync1_q != sync2_q) begin
         cnt_d = {CW{1'b0}};
      end else if (sync2_q == db_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         db_d  = sync2_q;
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= {WIDTH{1'b0}};
         sync2_q <= {WIDTH{1'b0}};
         db_q    <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/btn_encoder.sv
// Debounced 4-button priority encoder with valid/ready event output and a
// sticky overrun flag. Define BTN_ENCODER_REPEAT_EN to enable auto-repeat.
module btn_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   output logic [1:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       overrun
);

   import btn_enc_pkg::*;

   logic [3:0] db_s;
   logic       fire_s;
   state_e     state_q;
   state_e     state_d;
   code_t      code_q;
   code_t      code_d;
   logic       valid_q;
   logic       valid_d;
   logic       overrun_q;
   logic       overrun_d;
   logic       rel_q;
   logic       rel_d;

`ifdef BTN_ENCODER_REPEAT_EN
   localparam int unsigned RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rpt_q;
   logic [RW-1:0] rpt_d;
   logic [3:0]    db_prev_q;
`endif

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .WIDTH          (4)
   ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_i(btn),
      .db_o (db_s)
   );

   assign fire_s = valid_q & ready;

   // rel_q remembers a full release seen while an event is still pending.
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      overrun_d = overrun_q;
      rel_d     = 1'b0;
`ifdef BTN_ENCODER_REPEAT_EN
      rpt_d     = {RW{1'b0}};
`endif
      case (state_q)
         IDLE: begin
            if (db_s != 4'b0000) begin
               state_d = PEND;
               code_d  = prio_enc(db_s);
            end else begin
               state_d = IDLE;
            end
         end
         PEND: begin
            if (fire_s) begin
               if (db_s != 4'b0000) begin
                  state_d = HELD;
`ifdef BTN_ENCODER_REPEAT_EN
                  rpt_d   = RW'(1);
`endif
               end else begin
                  state_d = IDLE;
               end
            end else if (db_s == 4'b0000) begin
               rel_d = 1'b1;
            end else if (rel_q) begin
               overrun_d = 1'b1;
            end else begin
               rel_d = 1'b0;
            end
         end
         HELD: begin
            if (db_s == 4'b0000) begin
               state_d = IDLE;
`ifdef BTN_ENCODER_REPEAT_EN
            end else if (db_s != db_prev_q) begin
               rpt_d = {RW{1'b0}};
            end else if (rpt_q == RPT_LAST) begin
               state_d = PEND;
            end else begin
               rpt_d = rpt_q + RW'(1);
            end
`else
            end else begin
               state_d = HELD;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      valid_d = (state_d == PEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         code_q    <= 2'b00;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         rel_q     <= 1'b0;
`ifdef BTN_ENCODER_REPEAT_EN
         rpt_q     <= {RW{1'b0}};
         db_prev_q <= 4'b0000;
`endif
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         rel_q     <= rel_d;
`ifdef BTN_ENCODER_REPEAT_EN
         rpt_q     <= rpt_d;
         db_prev_q <= db_s;
`endif
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: doc/btn_encoder.md
BTN_ENCODER -- requirements
Module: btn_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable synchronized samples required to accept a new button pattern (minimum 1).
REQ-002 Parameter REPEAT_CYCLES, default 5000000, is the number of cycles a held button waits before each auto-repeat event (used only under REQ-021).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous assertion, active-low.
REQ-005 Port btn  input  4  carries raw, asynchronous, bouncing push-button levels; 1 means pressed.
REQ-006 Port code  output  2  is the encoded index of the accepted button.
REQ-007 Port valid  output  1  is high while a press event is offered on code.
REQ-008 Port ready  input  1  is the consumer acceptance; an event transfers on a cycle where valid and ready are both high.
REQ-009 Port overrun  output  1  is a sticky flag: a press event was lost because valid was still pending.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 The debounced pattern db[3:0] SHALL take the synchronized value once that value differs from db and stays unchanged for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count from zero.
REQ-012 Encoding SHALL be priority-based: the highest set bit of db wins (btn[3] gives code 2'b11, btn[0] gives code 2'b00).
REQ-013 The FSM SHALL have three states: IDLE (db == 0), PEND (valid high), HELD (event delivered, db != 0).
REQ-014 IDLE -> PEND when db becomes non-zero; code is latched from db at that transition and stays constant while in PEND.
REQ-015 PEND -> HELD on the handshake cycle if db != 0; PEND -> IDLE on the handshake cycle if db == 0.
REQ-016 In PEND without ready, release and re-press of any button (db goes 0 then non-zero) SHALL set overrun; the pending code is not overwritten.
REQ-017 HELD -> IDLE when db == 0; a pattern change in HELD while db stays non-zero SHALL NOT generate an event.
REQ-018 Latency: a clean btn change stable from cycle t SHALL raise valid at cycle t+3+DEBOUNCE_CYCLES.
REQ-019 valid SHALL be a registered output and never toggle while code changes; overrun clears only on reset.

Reset
REQ-020 While rst_n is low: synchronizers, db, counters and overrun are 0, the FSM is IDLE, and code = 2'b00, valid = 0; reset during PEND drops the event, and a button held through reset release generates a fresh event after the debounce time.

Configuration
REQ-021 With BTN_ENCODER_REPEAT_EN defined: in HELD, a repeat counter SHALL re-enter PEND with the same code every REPEAT_CYCLES cycles while db is unchanged and non-zero, and it clears when db changes; without the macro there is no repeat counter and HELD waits only for release.

Structure
REQ-022 Package btn_enc_pkg SHALL hold the FSM state enum (IDLE, PEND, HELD), the 2-bit code typedef and the priority-encode function.
REQ-023 Synchronizer plus debounce SHALL be one sub-module, btn_debounce, instantiated once for the 4-bit vector.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-024 Clean btn=4'b0100 from cycle 10 with ready=1 -> valid high at cycle 17 only, code=2'b10, then state HELD.
REQ-025 btn toggling 0100/0000 every 2 cycles for 12 cycles, then stable 0100 -> exactly one event, code=2'b10.
REQ-026 btn=4'b1001 -> code=2'b11; with ready=0, release then press 0001 -> overrun=1, code stays 2'b11.
REQ-027 rst_n pulsed low during PEND while btn held -> valid=0 immediately; a new event arrives 7 cycles after rst_n rises.
REQ-028 With the macro defined, hold 0010 for 60 cycles with ready=1 -> one initial event plus repeats every 20 cycles, all code=2'b01; without the macro -> exactly one event.
